// File: rtl/ram_key_ctrl.sv
// ram_key_ctrl: sequences a 16x4 synchronous-read block RAM from two push-buttons and a switch bank.
//
// Ports:
//   clk_50    in   system clock, all logic on rising edge
//   rst       in   synchronous active-high reset
//   key       in   raw active-low push-buttons: [0] next address, [1] write
//   sw        in   write data, asynchronous, quasi-static
//   ram_addr  out  RAM address (clear counter during INIT, current address otherwise)
//   ram_wdata out  RAM write data (0 during INIT, captured switches during WRITE)
//   ram_we    out  RAM write enable, high only in INIT and WRITE
//   ram_rdata in   RAM read data, valid one cycle after the address
//   led       out  word read from the current address
//   busy      out  high whenever the controller is not idle
//
// Build option: define RAM_KEY_CTRL_DEBOUNCE_EN to debounce the keys with a
// DEBOUNCE_CYC stable-cycle counter; otherwise the synchronized key level is used directly.
module ram_key_ctrl #(
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 4,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic [1:0]        key,
    input  logic [DATA_W-1:0] sw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] led,
    output logic              busy
);
    typedef enum logic [2:0] {INIT, IDLE, WRITE, READ, LATCH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [1:0]        key_s1_q, key_s2_q, lvl_prev_q, press_q;
    logic [1:0]        lvl;
    logic [DATA_W-1:0] sw_s1_q, sw_s2_q;

    // Synchronizers and falling-edge detect; press_q is the registered edge pulse.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            key_s1_q   <= '1;
            key_s2_q   <= '1;
            lvl_prev_q <= '1;
            press_q    <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
        end else begin
            key_s1_q   <= key;
            key_s2_q   <= key_s1_q;
            lvl_prev_q <= lvl;
            press_q    <= lvl_prev_q & ~lvl;
            sw_s1_q    <= sw;
            sw_s2_q    <= sw_s1_q;
        end
    end

`ifdef RAM_KEY_CTRL_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    for (genvar i = 0; i < 2; i++) begin : g_db
        logic [CNT_W-1:0] cnt_q;
        logic             db_q;
        // Level is accepted only after it has differed for DEBOUNCE_CYC consecutive cycles.
        always_ff @(posedge clk_50) begin
            if (rst) begin
                cnt_q <= '0;
                db_q  <= 1'b1;
            end else if (key_s2_q[i] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
                cnt_q <= '0;
                db_q  <= key_s2_q[i];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign lvl[i] = db_q;
    end
`else
    logic unused_debounce;
    assign unused_debounce = ^DEBOUNCE_CYC;
    assign lvl = key_s2_q;
`endif

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state_q <= INIT;
            addr_q  <= '0;
            wdata_q <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            led_q   <= led_d;
        end
    end

    // INIT reuses the address register as the clear counter; it wraps to 0 on the
    // last word, which is exactly the current address wanted when entering READ.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        led_d   = led_q;
        case (state_q)
            INIT: begin
                addr_d  = addr_q + 1'b1;
                state_d = (&addr_q) ? READ : INIT;
            end
            IDLE: begin
                if (press_q[1]) begin
                    state_d = WRITE;
                    wdata_d = sw_s2_q;
                end else if (press_q[0]) begin
                    state_d = READ;
                    addr_d  = addr_q + 1'b1;
                end
            end
            WRITE:   state_d = READ;
            READ:    state_d = LATCH;
            LATCH: begin
                state_d = IDLE;
                led_d   = ram_rdata;
            end
            default: state_d = INIT;
        endcase
    end

    // Write enable is masked by reset so no word is written while reset is held.
    assign ram_we    = ~rst & ((state_q == INIT) | (state_q == WRITE));
    assign ram_addr  = addr_q;
    assign ram_wdata = (state_q == WRITE) ? wdata_q : '0;
    assign led       = led_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_ram_key_ctrl.sv
// tb_ram_key_ctrl: self-checking bench for ram_key_ctrl with a behavioural RAM and reference model.
module tb_ram_key_ctrl;
    localparam int D = 8;
`ifdef RAM_KEY_CTRL_DEBOUNCE_EN
    localparam int LAT = 4 + D;
`else
    localparam int LAT = 4;
`endif

    logic       clk_50 = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] key = 2'b11;
    logic [3:0] sw = 4'h0;
    logic [3:0] ram_addr, ram_wdata, ram_rdata, led;
    logic       ram_we, busy;

    logic [3:0] ram [16];
    logic       seed_en = 1'b0;
    logic [3:0] seed_idx = 4'h0, seed_val = 4'h0;

    int ntests = 0, nfail = 0;
    logic [3:0] mem [16];
    int m_addr = 0;

    typedef struct {
        int         op;
        logic [3:0] swv;
        logic [3:0] ea;
        logic [3:0] el;
    } vec_t;
    vec_t tbl [21];

    ram_key_ctrl #(.ADDR_W(4), .DATA_W(4), .DEBOUNCE_CYC(D)) dut (
        .clk_50(clk_50),
        .rst(rst),
        .key(key),
        .sw(sw),
        .ram_addr(ram_addr),
        .ram_wdata(ram_wdata),
        .ram_we(ram_we),
        .ram_rdata(ram_rdata),
        .led(led),
        .busy(busy)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) begin
        if (seed_en) ram[seed_idx] <= seed_val;
        else if (ram_we) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic init_seq();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_50);
            chk("init_we", int'(ram_we), 1);
            chk("init_addr", int'(ram_addr), i);
            chk("init_wdata", int'(ram_wdata), 0);
            chk("init_busy", int'(busy), 1);
        end
        @(negedge clk_50);
        chk("init_read_we", int'(ram_we), 0);
        chk("init_read_addr", int'(ram_addr), 0);
        @(negedge clk_50);
        chk("init_latch_we", int'(ram_we), 0);
        chk("init_latch_busy", int'(busy), 1);
        @(negedge clk_50);
        chk("init_ready_busy", int'(busy), 0);
        chk("init_ready_led", int'(led), 0);
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        m_addr = 0;
    endtask

    // op: 0 = key[0] step, 1 = key[1] write, 2 = both keys together
    task automatic do_op(input int op, input logic [3:0] swv, input logic [3:0] ea, input logic [3:0] el);
        int n = 0;
        sw = swv;
        repeat (3) @(negedge clk_50);
        key = (op == 0) ? 2'b10 : (op == 1) ? 2'b01 : 2'b00;
        do begin
            @(negedge clk_50);
            n++;
        end while (!busy && n < LAT + 20);
        chk("press_latency", n, LAT);
        if (op != 0) begin
            chk("wr_we", int'(ram_we), 1);
            chk("wr_addr", int'(ram_addr), int'(ea));
            chk("wr_data", int'(ram_wdata), int'(swv));
            @(negedge clk_50);
        end
        chk("rd_we", int'(ram_we), 0);
        chk("rd_addr", int'(ram_addr), int'(ea));
        chk("rd_busy", int'(busy), 1);
        @(negedge clk_50);
        chk("lt_we", int'(ram_we), 0);
        chk("lt_busy", int'(busy), 1);
        @(negedge clk_50);
        chk("led", int'(led), int'(el));
        chk("idle_busy", int'(busy), 0);
        key = 2'b11;
        n = 0;
        repeat (LAT + 4) begin
            @(negedge clk_50);
            n += int'(busy | ram_we);
        end
        chk("release_quiet", n, 0);
    endtask

    initial begin
        int n, wes;
        tbl[0] = '{1, 4'hA, 4'h0, 4'hA};
        for (int i = 1; i < 16; i++) tbl[i] = '{0, 4'h0, 4'(i), 4'h0};
        tbl[16] = '{0, 4'h0, 4'h0, 4'hA};
        for (int i = 17; i < 20; i++) tbl[i] = '{0, 4'h0, 4'(i - 16), 4'h0};
        tbl[20] = '{2, 4'h5, 4'h3, 4'h5};

        seed_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            seed_idx = 4'(i);
            seed_val = 4'($urandom_range(1, 15));
            @(negedge clk_50);
        end
        seed_en = 1'b0;
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_wdata", int'(ram_wdata), 0);
        chk("rst_we", int'(ram_we), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 1);
        @(posedge clk_50);
        #1 rst = 1'b0;
        init_seq();

        for (int i = 0; i < 21; i++) begin
            if (tbl[i].op == 0) m_addr = (m_addr + 1) % 16;
            else mem[m_addr] = tbl[i].swv;
            do_op(tbl[i].op, tbl[i].swv, tbl[i].ea, tbl[i].el);
        end

        // key[0] arrives one cycle after key[1]: it lands while busy and must be dropped
        sw = 4'h9;
        repeat (3) @(negedge clk_50);
        key = 2'b01;
        @(negedge clk_50);
        key = 2'b00;
        n = 0;
        do begin
            @(negedge clk_50);
            n++;
        end while (!busy && n < LAT + 20);
        chk("drop_busy", int'(busy), 1);
        n = 0;
        wes = 0;
        while (busy && n < 20) begin
            wes += int'(ram_we);
            @(negedge clk_50);
            n++;
        end
        chk("drop_we_pulses", wes, 1);
        chk("drop_led", int'(led), 9);
        key = 2'b11;
        n = 0;
        repeat (LAT + 6) begin
            @(negedge clk_50);
            n += int'(busy | ram_we);
        end
        chk("drop_quiet", n, 0);
        mem[m_addr] = 4'h9;

`ifdef RAM_KEY_CTRL_DEBOUNCE_EN
        n = 0;
        for (int r = 0; r < 3; r++) begin
            key = 2'b10;
            repeat (D - 2) begin
                @(negedge clk_50);
                n += int'(busy | ram_we);
            end
            key = 2'b11;
            repeat (2) begin
                @(negedge clk_50);
                n += int'(busy | ram_we);
            end
        end
        repeat (LAT + 4) begin
            @(negedge clk_50);
            n += int'(busy | ram_we);
        end
        chk("bounce_nopress", n, 0);
        m_addr = (m_addr + 1) % 16;
        do_op(0, 4'h0, 4'(m_addr), mem[m_addr]);
`endif

        for (int i = 0; i < 40; i++) begin
            int op;
            logic [3:0] v;
            op = int'($urandom_range(0, 2));
            v = 4'($urandom);
            if (op == 0) m_addr = (m_addr + 1) % 16;
            else mem[m_addr] = v;
            do_op(op, v, 4'(m_addr), mem[m_addr]);
        end

        // reset while the write is in progress
        sw = 4'h7;
        repeat (3) @(negedge clk_50);
        key = 2'b01;
        n = 0;
        do begin
            @(negedge clk_50);
            n++;
        end while (!busy && n < LAT + 20);
        chk("rstw_in_write", int'(ram_we), 1);
        rst = 1'b1;
        key = 2'b11;
        repeat (3) begin
            @(negedge clk_50);
            chk("rstw_we", int'(ram_we), 0);
            chk("rstw_led", int'(led), 0);
            chk("rstw_busy", int'(busy), 1);
            chk("rstw_addr", int'(ram_addr), 0);
        end
        @(posedge clk_50);
        #1 rst = 1'b0;
        init_seq();
        for (int i = 0; i < 16; i++) begin
            m_addr = (m_addr + 1) % 16;
            do_op(0, 4'h0, 4'(m_addr), mem[m_addr]);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/ram_key_ctrl.md
# ram_key_ctrl

Controller that sequences the on-board 16×4 block RAM of the DE10 key/LED demo. Conditions the two push-buttons, clears the RAM after reset, steps the current address on `key[0]`, writes the switch value on `key[1]`, and refreshes the LEDs with the word at the current address. Sits between board I/O (keys, switches, LEDs) and the synchronous-read RAM primitive.

## Interface
Parameters:
- `ADDR_W`, 4, RAM address width; depth = 2^ADDR_W
- `DATA_W`, 4, RAM word width, equals LED and switch width
- `DEBOUNCE_CYC`, 500000, consecutive stable cycles required to accept a key level (10 ms at 50 MHz)

Ports:
- `clk_50`  in  1  system clock, 50 MHz; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `key`  in  2  raw push-buttons, active-low, asynchronous; [0] = next address, [1] = write
- `sw`  in  DATA_W  write data, asynchronous, quasi-static
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_we`  out  1  RAM write enable, one cycle per write
- `ram_rdata`  in  DATA_W  RAM read data, valid one cycle after address is presented
- `led`  out  DATA_W  displayed word at current address
- `busy`  out  1  high whenever FSM is not in IDLE

## Operation
- Key conditioning, per key: 2-flop synchronizer, then debounce (see Configuration), then edge detect; `press[i]` is a 1-cycle pulse when the debounced level goes 1→0. Debounced levels reset to 1 (released).
- `sw` captured through a 2-flop synchronizer; the synchronized value at the press cycle is the value written.
- FSM states: INIT, IDLE, WRITE, READ, LATCH.
- INIT: `ram_we`=1, `ram_wdata`=0, `ram_addr` counts 0..2^ADDR_W−1, one word per cycle; after last address → READ with current address 0.
- IDLE: `ram_we`=0. `press[1]` → WRITE; else `press[0]` → current address +1 (wraps 2^ADDR_W−1 → 0), → READ.
- WRITE: `ram_we`=1 for exactly one cycle, `ram_addr` = current address, `ram_wdata` = captured `sw`; → READ.
- READ: `ram_addr` = current address, `ram_we`=0; → LATCH.
- LATCH: `led` ← `ram_rdata`; → IDLE.
- Simultaneous `press[0]` and `press[1]` in IDLE: write wins, address unchanged, the `key[0]` press is dropped.
- Presses arriving while `busy`=1 are dropped (no queuing).
- Reset mid-operation (any state): return to INIT, current address 0, `led` 0; full RAM clear repeats.

## Timing
- Reset values while `rst`=1: `ram_addr`=0, `ram_wdata`=0, `ram_we`=0, `led`=0, `busy`=1.
- First cycle after `rst` deasserts: INIT, `ram_we`=1, `ram_addr`=0. INIT lasts 2^ADDR_W cycles (16 default); READ, LATCH follow; `led`=word 0 (=0) and `busy`=0 at cycle 19 after reset release.
- Address step: `press[0]` in IDLE at cycle P → READ at P+1 with new `ram_addr`; LATCH at P+2; `led` updated and `busy`=0 at P+3.
- Write: `press[1]` at P → WRITE at P+1 (`ram_we`=1); READ P+2; LATCH P+3; `led` shows written value at P+4.
- Key-to-press latency: 2 sync cycles + DEBOUNCE_CYC (+1 edge register) with debounce; 3 cycles without.
- `ram_we` never high outside INIT and WRITE.

## Configuration
- `RAM_KEY_CTRL_DEBOUNCE_EN` defined: per-key counter; debounced level updates only after the synchronized level differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
- Undefined: debounced level = synchronized level directly (simulation/fast bench); DEBOUNCE_CYC unused.

## Test plan
- Reset release → `ram_we`=1 for 16 cycles, addresses 0..15, data 0; `led`=0, `busy`=0 at cycle 19.
- `sw`=4'hA, press `key[1]` at address 0 → one `ram_we` pulse with addr 0, data 4'hA; `led`=4'hA 4 cycles after press.
- Press `key[0]` 16 times from address 0 → address 15 then wraps to 0; `led` shows 4'hA again on the wrap.
- Both keys pressed same cycle with `sw`=4'h5 at address 3 → address 3 written with 4'h5, address stays 3, `led`=4'h5.
- With macro defined, `key[0]` bounce pulses shorter than DEBOUNCE_CYC → no press; stable low ≥ DEBOUNCE_CYC → exactly one address step.
- Assert `rst` during WRITE → `ram_we`=0 and `led`=0 while reset; INIT reruns, all 16 words read back 0.
